irrigation_zone_scheduler: RTL and testbench

- Shares one water pump among ZONES irrigation zones, each with a soil-dry request line.
- Grants zones round-robin and opens the granted zone's valve.
- Waits for the valve to settle, then runs the pump for a bounded watering time and enforces a pause before the next grant.
- Sits between the zone sensor front-end and the valve/pump drivers. Its timers are plain synchronous counters.

---
 rtl/irrigation_zone_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_irrigation_zone_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_zone_scheduler.sv
// rtl/irrigation_zone_scheduler.sv - round-robin pump sharing scheduler for irrigation zones
//
// Ports:
//   clock        rising-edge system clock
//   reset        asynchronous active-low reset
//   enable       1 allows new grants (does not stop a grant in progress)
//   tank_low     1 = reservoir empty, aborts settle/water
//   req          per-zone soil-dry request, level-sensitive
//   valve        one-hot valve drive, zero when no zone is granted
//   pump         pump drive
//   active_zone  index of the granted zone, holds its last value while idle
//   busy         high in SETTLE, WATER and PAUSE
//   done         one-cycle pulse when watering completes without abort
//   alarm        tank-low indication, cleared only in IDLE once tank_low=0
module irrigation_zone_scheduler #(
    parameter int ZONES         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int WATER_CYCLES  = 16,
    parameter int PAUSE_CYCLES  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     tank_low,
    input  logic [ZONES-1:0]         req,
    output logic [ZONES-1:0]         valve,
    output logic                     pump,
    output logic [$clog2(ZONES)-1:0] active_zone,
    output logic                     busy,
    output logic                     done,
    output logic                     alarm
);

    localparam int ZW = $clog2(ZONES);

    localparam int MAX_SW = (SETTLE_CYCLES > WATER_CYCLES) ? SETTLE_CYCLES : WATER_CYCLES;
    localparam int MAXC   = (MAX_SW > PAUSE_CYCLES) ? MAX_SW : PAUSE_CYCLES;
    // The timer counts down from N-1 to 0, so it only has to hold MAXC-1.
    localparam int TW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WATER  = 2'd2,
        PAUSE  = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic [ZW-1:0]   rr_ptr, rr_nx;
    logic [ZONES-1:0] valve_nx;
    logic            pump_nx;
    logic [ZW-1:0]   zone_nx;
    logic            busy_nx;
    logic            done_nx;
    logic            alarm_nx;

    logic            grant_found;
    logic [ZW-1:0]   grant;
    logic [ZW-1:0]   ptr_after;
    logic            to_pause;

    // Round-robin search: first requesting zone at or above rr_ptr, wrapping.
    always_comb begin
        int            idx;
        logic [ZW-1:0] idx_z;
        grant_found = 1'b0;
        grant       = '0;
        idx         = 0;
        idx_z       = '0;
        for (int i = 0; i < ZONES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= ZONES) begin
                idx = idx - ZONES;
            end
            idx_z = ZW'(idx);
            if (!grant_found && req[idx_z]) begin
                grant_found = 1'b1;
                grant       = idx_z;
            end
        end
    end

    // Pointer value that follows the current grant; loaded on PAUSE entry.
    always_comb begin
        if (active_zone == ZW'(ZONES - 1)) begin
            ptr_after = '0;
        end else begin
            ptr_after = active_zone + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        rr_nx    = rr_ptr;
        valve_nx = valve;
        pump_nx  = pump;
        zone_nx  = active_zone;
        busy_nx  = busy;
        done_nx  = 1'b0;
        alarm_nx = alarm;
        to_pause = 1'b0;

        if (tank_low) begin
            alarm_nx = 1'b1;
        end else if (state == IDLE) begin
            alarm_nx = 1'b0;
        end

        case (state)
            IDLE: begin
                if (enable && !tank_low && grant_found) begin
                    state_nx = SETTLE;
                    timer_nx = TW'(SETTLE_CYCLES - 1);
                    valve_nx = {{(ZONES-1){1'b0}}, 1'b1} << grant;
                    pump_nx  = 1'b0;
                    zone_nx  = grant;
                    busy_nx  = 1'b1;
                end
            end
            SETTLE: begin
                if (tank_low) begin
                    to_pause = 1'b1;
                end else if (timer == '0) begin
                    state_nx = WATER;
                    timer_nx = TW'(WATER_CYCLES - 1);
                    pump_nx  = 1'b1;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            WATER: begin
                if (tank_low) begin
                    to_pause = 1'b1;
                end else if (!req[active_zone] || timer == '0) begin
                    to_pause = 1'b1;
                    done_nx  = 1'b1;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            PAUSE: begin
                if (timer == '0) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                    busy_nx  = 1'b0;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
                valve_nx = '0;
                pump_nx  = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase

        // Normal end and tank-low abort share the same exit; only done differs.
        if (to_pause) begin
            state_nx = PAUSE;
            timer_nx = TW'(PAUSE_CYCLES - 1);
            valve_nx = '0;
            pump_nx  = 1'b0;
            rr_nx    = ptr_after;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            rr_ptr      <= '0;
            valve       <= '0;
            pump        <= 1'b0;
            active_zone <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            rr_ptr      <= rr_nx;
            valve       <= valve_nx;
            pump        <= pump_nx;
            active_zone <= zone_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            alarm       <= alarm_nx;
        end
    end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// tb/tb_irrigation_zone_scheduler.sv - scoreboard bench for irrigation_zone_scheduler
module tb_irrigation_zone_scheduler;

    localparam int ZONES = 4;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             tank_low;
    logic [ZONES-1:0] req;
    logic [ZONES-1:0] valve;
    logic             pump;
    logic [1:0]       active_zone;
    logic             busy;
    logic             done;
    logic             alarm;

    irrigation_zone_scheduler #(
        .ZONES(ZONES), .SETTLE_CYCLES(2), .WATER_CYCLES(16), .PAUSE_CYCLES(4)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .tank_low(tank_low),
        .req(req), .valve(valve), .pump(pump), .active_zone(active_zone),
        .busy(busy), .done(done), .alarm(alarm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int zone;
        int settle;
        int pumpn;
        int donen;
        int pause;
    } rec_t;

    rec_t sb[$];
    rec_t cur;
    bit   rec_active = 1'b0;

    function automatic int onehot_index(input logic [ZONES-1:0] v);
        int r = -1;
        for (int i = 0; i < ZONES; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic expect_grant(input int zone, input int pumpn, input int donen);
        rec_t r;
        r.zone   = zone;
        r.settle = 2;
        r.pumpn  = pumpn;
        r.donen  = donen;
        r.pause  = 4;
        sb.push_back(r);
    endtask

    // Monitor: builds one record per grant (valve rise .. busy fall) and
    // compares it with the oldest expectation.
    always @(negedge clock) begin
        if (!reset) begin
            rec_active = 1'b0;
        end else begin
            check("valve_zero_or_onehot", ($countones(valve) <= 1), 1);
            if (pump) check("pump_needs_one_valve", $countones(valve), 1);
            if (!rec_active) begin
                if (valve != '0) begin
                    rec_active = 1'b1;
                    cur.zone   = onehot_index(valve);
                    cur.settle = 1;
                    cur.pumpn  = 0;
                    cur.donen  = 0;
                    cur.pause  = 0;
                end
            end else begin
                if (valve != '0) begin
                    if (pump) cur.pumpn++;
                    else cur.settle++;
                end else if (busy) begin
                    cur.pause++;
                end
                if (done) cur.donen++;
                if (!busy) begin
                    rec_active = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_grant", 1, 0);
                    end else begin
                        rec_t e;
                        e = sb.pop_front();
                        check("grant_zone", cur.zone, e.zone);
                        check("active_zone_hold", active_zone, e.zone);
                        check("settle_cycles", cur.settle, e.settle);
                        check("pump_cycles", cur.pumpn, e.pumpn);
                        check("done_pulses", cur.donen, e.donen);
                        check("pause_cycles", cur.pause, e.pause);
                    end
                end
            end
        end
    end

    // sel: 0 = pump high, 1 = done high, 2 = busy low
    task automatic wait_until(input string tag, input int sel, input int bound);
        bit hit = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clock);
            #1;
            case (sel)
                0: hit = pump;
                1: hit = done;
                default: hit = !busy;
            endcase
            if (hit) break;
        end
        if (!hit) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        wait_until(tag, 2, 60);
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        enable   = 1'b0;
        tank_low = 1'b0;
        req      = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_valve", valve, 0);
        check("rst_pump", pump, 0);
        check("rst_zone", active_zone, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_alarm", alarm, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset    = 1'b0;
        enable   = 1'b0;
        tank_low = 1'b0;
        req      = '0;

        // single zone 2, full watering
        do_reset();
        enable = 1'b1;
        expect_grant(2, 16, 1);
        req = 4'b0100;
        @(posedge clock);
        #1;
        check("t1_valve_latency", valve, 4'b0100);
        check("t1_busy", busy, 1);
        wait_until("t1_done", 1, 40);
        req = '0;
        wait_idle("t1_idle");

        // all zones requesting: strict round robin
        do_reset();
        enable = 1'b1;
        expect_grant(0, 16, 1);
        expect_grant(1, 16, 1);
        expect_grant(2, 16, 1);
        expect_grant(3, 16, 1);
        expect_grant(0, 16, 1);
        req = 4'b1111;
        n = 0;
        for (int i = 0; i < 200 && n < 5; i++) begin
            @(posedge clock);
            #1;
            if (done) n++;
        end
        req = '0;
        check("t2_done_count", n, 5);
        wait_idle("t2_idle");

        // early end when zone 0 soil turns wet on 5th pump cycle
        do_reset();
        enable = 1'b1;
        expect_grant(0, 5, 1);
        req = 4'b0001;
        wait_until("t3_pump", 0, 20);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        req = '0;
        @(posedge clock);
        #1;
        check("t3_pump_fall", pump, 0);
        check("t3_done", done, 1);
        wait_idle("t3_idle");
        // rr_ptr=1 means zone 1 beats zone 0
        expect_grant(1, 16, 1);
        req = 4'b0011;
        wait_until("t3b_done", 1, 40);
        req = '0;
        wait_idle("t3b_idle");

        // tank-low abort on 3rd pump cycle of zone 2
        do_reset();
        enable = 1'b1;
        expect_grant(2, 3, 0);
        req = 4'b0100;
        wait_until("t4_pump", 0, 20);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        tank_low = 1'b1;
        @(posedge clock);
        #1;
        check("t4_abort_pump", pump, 0);
        check("t4_abort_valve", valve, 0);
        check("t4_abort_done", done, 0);
        check("t4_alarm_set", alarm, 1);
        wait_idle("t4_idle");
        repeat (6) begin
            @(posedge clock);
            #1;
        end
        check("t4_no_grant_valve", valve, 0);
        check("t4_no_grant_busy", busy, 0);
        check("t4_alarm_hold", alarm, 1);
        tank_low = 1'b0;
        req      = '0;
        @(posedge clock);
        #1;
        check("t4_alarm_clear", alarm, 0);

        // enable gating
        do_reset();
        enable = 1'b0;
        req    = 4'b0010;
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        check("t5_gated_valve", valve, 0);
        check("t5_gated_busy", busy, 0);
        expect_grant(1, 16, 1);
        enable = 1'b1;
        @(posedge clock);
        #1;
        check("t5_grant_valve", valve, 4'b0010);
        check("t5_grant_zone", active_zone, 1);
        wait_until("t5_done", 1, 40);
        req = '0;
        wait_idle("t5_idle");

        // asynchronous reset in WATER (rr_ptr is 2 here beforehand)
        req = 4'b0100;
        wait_until("t6_pump", 0, 20);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("t6_async_pump", pump, 0);
        check("t6_async_valve", valve, 0);
        check("t6_async_busy", busy, 0);
        req = '0;
        @(posedge clock);
        #1;
        check("t6_rst_zone", active_zone, 0);
        reset = 1'b1;
        expect_grant(0, 16, 1);
        req = 4'b1111;
        wait_until("t6_done", 1, 40);
        req = '0;
        wait_idle("t6_idle");

        check("sb_leftover", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
